// File: rtl/keycode_morse_encoder_pkg.sv
// ============================================================================
// Module      : keycode_morse_encoder_pkg
// Description : Shared Morse definitions: FSM states, key-index -> hex/Morse table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keycode_morse_encoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_MARK     = 3'd2,
        ST_SPACE    = 3'd3,
        ST_CHAR_GAP = 3'd4
    } state_t;

    // Pattern is left-aligned: pattern[4] is the first symbol, 1 = dash.
    typedef struct packed {
        logic [3:0] hex;
        logic [2:0] len;
        logic [4:0] pattern;
    } key_entry_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Bit 3 is line 0 (row0 / col0), bit 0 is line 3.
    function automatic logic [1:0] line_pos(input logic [3:0] v);
        logic [1:0] pos;
        pos = 2'd0;
        if (v[2]) pos = 2'd1;
        if (v[1]) pos = 2'd2;
        if (v[0]) pos = 2'd3;
        return pos;
    endfunction

    function automatic key_entry_t key_entry(input logic [3:0] idx);
        key_entry_t e;
        case (idx)
            4'd0:    e = '{4'h1, 3'd5, 5'b01111};
            4'd1:    e = '{4'h2, 3'd5, 5'b00111};
            4'd2:    e = '{4'h3, 3'd5, 5'b00011};
            4'd3:    e = '{4'hA, 3'd2, 5'b01000};
            4'd4:    e = '{4'h4, 3'd5, 5'b00001};
            4'd5:    e = '{4'h5, 3'd5, 5'b00000};
            4'd6:    e = '{4'h6, 3'd5, 5'b10000};
            4'd7:    e = '{4'hB, 3'd4, 5'b10000};
            4'd8:    e = '{4'h7, 3'd5, 5'b11000};
            4'd9:    e = '{4'h8, 3'd5, 5'b11100};
            4'd10:   e = '{4'h9, 3'd5, 5'b11110};
            4'd11:   e = '{4'hC, 3'd4, 5'b10100};
            4'd12:   e = '{4'hE, 3'd1, 5'b00000};
            4'd13:   e = '{4'h0, 3'd5, 5'b11111};
            4'd14:   e = '{4'hF, 3'd4, 5'b00100};
            default: e = '{4'hD, 3'd3, 5'b10000};
        endcase
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keycode_morse_encoder_filter.sv
// ============================================================================
// Module      : key_code_filter
// Description : Validity check, stability counter and repeat suppression for keyCode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_code_filter
    import keycode_morse_encoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_code_i,
    input  logic       idle_i,
    output logic       accept_o,
    output logic [3:0] key_idx_o
);

    localparam int              c_CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES - 1);

    logic [7:0]         prev_code_q;
    logic [7:0]         last_code_q, last_code_d;
    logic [c_CNT_W-1:0] stab_cnt_q,  stab_cnt_d;
    logic               w_valid;
    logic               w_same;

    assign w_valid = is_onehot4(key_code_i[7:4]) && is_onehot4(key_code_i[3:0]);
    assign w_same  = (key_code_i == prev_code_q);

    assign accept_o = idle_i && (stab_cnt_q == c_CNT_MAX) && w_same && w_valid
                      && (key_code_i != last_code_q);

    // last_code_q holds the accepted code, so the index stays stable through LOAD.
    assign key_idx_o = {line_pos(last_code_q[7:4]), line_pos(last_code_q[3:0])};

    always_comb begin
        stab_cnt_d  = stab_cnt_q;
        last_code_d = last_code_q;
        if (!w_same || !w_valid) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != c_CNT_MAX) begin
            stab_cnt_d = stab_cnt_q + c_CNT_W'(1);
        end
        if (accept_o) begin
            last_code_d = key_code_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_code_q <= 8'h00;
            last_code_q <= 8'h00;
            stab_cnt_q  <= '0;
        end else begin
            prev_code_q <= key_code_i;
            last_code_q <= last_code_d;
            stab_cnt_q  <= stab_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/keycode_morse_encoder.sv
// ============================================================================
// Module      : keycode_morse_encoder
// Description : Plays the debounced keypad character as Morse timing on morse_out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keycode_morse_encoder
    import keycode_morse_encoder_pkg::*;
#(
    parameter int UNIT_CYCLES   = 25_000_000,
    parameter int STABLE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_code,
    output logic       morse_out,
    output logic       busy,
    output logic       char_valid,
    output logic [3:0] char_idx
);

    localparam int                 c_TMR_W   = $clog2(3 * UNIT_CYCLES);
    localparam logic [c_TMR_W-1:0] c_DOT_M1  = c_TMR_W'(UNIT_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_DASH_M1 = c_TMR_W'(3 * UNIT_CYCLES - 1);

    state_t             state_q,    state_d;
    logic [c_TMR_W-1:0] timer_q,    timer_d;
    logic [2:0]         sym_left_q, sym_left_d;
    logic [4:0]         pattern_q,  pattern_d;
    logic [3:0]         char_idx_q, char_idx_d;
    logic               morse_q,    morse_d;
    logic               w_accept;
    logic [3:0]         w_key_idx;
    key_entry_t         w_entry;

    key_code_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk        (clk),
        .rst        (rst),
        .key_code_i (key_code),
        .idle_i     (state_q == ST_IDLE),
        .accept_o   (w_accept),
        .key_idx_o  (w_key_idx)
    );

    assign w_entry = key_entry(w_key_idx);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        sym_left_d = sym_left_q;
        pattern_d  = pattern_q;
        char_idx_d = char_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pattern_d  = w_entry.pattern;
                sym_left_d = w_entry.len - 3'd1;
                char_idx_d = w_entry.hex;
                timer_d    = w_entry.pattern[4] ? c_DASH_M1 : c_DOT_M1;
                state_d    = ST_MARK;
            end
            ST_MARK: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - c_TMR_W'(1);
                end else if (sym_left_q != 3'd0) begin
                    timer_d = c_DOT_M1;
                    state_d = ST_SPACE;
                end else begin
                    timer_d = c_DASH_M1;
                    state_d = ST_CHAR_GAP;
                end
            end
            ST_SPACE: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - c_TMR_W'(1);
                end else begin
                    // pattern_q[3] is the symbol that becomes current after the shift
                    pattern_d  = {pattern_q[3:0], 1'b0};
                    sym_left_d = sym_left_q - 3'd1;
                    timer_d    = pattern_q[3] ? c_DASH_M1 : c_DOT_M1;
                    state_d    = ST_MARK;
                end
            end
            ST_CHAR_GAP: begin
                if (timer_q != '0) timer_d = timer_q - c_TMR_W'(1);
                else               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        morse_d = (state_d == ST_MARK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            sym_left_q <= 3'd0;
            pattern_q  <= 5'd0;
            char_idx_q <= 4'd0;
            morse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sym_left_q <= sym_left_d;
            pattern_q  <= pattern_d;
            char_idx_q <= char_idx_d;
            morse_q    <= morse_d;
        end
    end

    assign morse_out  = morse_q;
    assign busy       = (state_q != ST_IDLE);
    assign char_valid = (state_q == ST_LOAD);
    assign char_idx   = char_idx_q;

endmodule

`default_nettype wire
